pe_dbuf: RTL and testbench

- Parametrised successor to the systolic-array PE: weight-stationary MAC cell with NUM_BANK weight banks, so the next tile's weights preload while the current tile computes.
- Adds synchronous reset, a swap token that travels with the data wavefront, a per-PE bypass mode, valid-gated accumulation and optional psum saturation.
- Sits in the 2-D PE grid: I/W/control forwarded horizontally, psum/addr/valid forwarded vertically.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_mac_sat.sv | 32 +++
 rtl/pe_dbuf.sv | 119 +++++++++++
 tb/tb_pe_dbuf.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared widths, psum bus layout and saturation bounds for the PE grid blocks.
package pe_pkg;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_PSUM_W   = 24;
  localparam int DEF_ROW_ID_W = 4;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_VALID_W  = 1;
  localparam int DEF_NUM_BANK = 2;
  localparam int BANK_W       = $clog2(DEF_NUM_BANK);

  localparam logic signed [DEF_PSUM_W-1:0] PSUM_MAX = {1'b0, {(DEF_PSUM_W-1){1'b1}}};
  localparam logic signed [DEF_PSUM_W-1:0] PSUM_MIN = {1'b1, {(DEF_PSUM_W-1){1'b0}}};

  typedef struct packed {
    logic signed [DEF_PSUM_W-1:0] psum;
    logic [DEF_ADDR_W-1:0]        addr;
    logic [DEF_VALID_W-1:0]       valid;
  } psum_bus_t;

  // Bank pointer width, kept at least one bit so a degenerate bank count still elaborates.
  function automatic int bank_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pe_mac_sat.sv
// Combinational signed multiply-add with optional clamp to the psum range.
// Out-of-range is detected from the extra guard bit of the PSUM_W+1 wide sum.
module pe_mac_sat #(
  parameter int DATA_W = 8,
  parameter int PSUM_W = 24,
  parameter bit SAT_EN = 1'b1
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic signed [PSUM_W-1:0] i_c,
  output logic signed [PSUM_W-1:0] o_sum,
  output logic                     o_sat_hit
);
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [PSUM_W:0]     w_wide;
  logic                       w_ovf;

  assign w_prod = i_a * i_b;
  assign w_wide = {{(PSUM_W+1-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod}
                + {i_c[PSUM_W-1], i_c};
  assign w_ovf  = w_wide[PSUM_W] ^ w_wide[PSUM_W-1];

  always_comb begin
    o_sum     = w_wide[PSUM_W-1:0];
    o_sat_hit = 1'b0;
    if (SAT_EN && w_ovf) begin
      o_sat_hit = 1'b1;
      // Guard bit carries the true sign of the unclamped sum.
      o_sum     = w_wide[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/pe_dbuf.sv
// Weight-stationary MAC PE with NUM_BANK weight banks: loads fill an idle bank while
// the active one computes; Swap advances the active bank with the data wavefront.
module pe_dbuf
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PSUM_W   = DEF_PSUM_W,
  parameter int ROW_ID_W = DEF_ROW_ID_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int VALID_W  = DEF_VALID_W,
  parameter int NUM_BANK = DEF_NUM_BANK,
  parameter bit SAT_EN   = 1'b1,
  localparam int BW      = bank_w(NUM_BANK)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [ROW_ID_W-1:0]        Row_ID,
  input  logic signed [DATA_W-1:0]   Data_I_In,
  output logic signed [DATA_W-1:0]   Data_I_Out,
  input  logic signed [DATA_W-1:0]   Data_W_In,
  output logic signed [DATA_W-1:0]   Data_W_Out,
  input  logic                       EN_W_In,
  output logic                       EN_W_Out,
  input  logic [ROW_ID_W-1:0]        EN_ID_In,
  output logic [ROW_ID_W-1:0]        EN_ID_Out,
  input  logic [BW-1:0]              Bank_W_In,
  output logic [BW-1:0]              Bank_W_Out,
  input  logic                       Swap_In,
  output logic                       Swap_Out,
  input  logic                       Byp_In,
  output logic                       Byp_Out,
  input  logic signed [PSUM_W-1:0]   Psum_In,
  output logic signed [PSUM_W-1:0]   Psum_Out,
  input  logic [ADDR_W-1:0]          Addr_P_In,
  output logic [ADDR_W-1:0]          Addr_P_Out,
  input  logic [VALID_W-1:0]         Valid_P_In,
  output logic [VALID_W-1:0]         Valid_P_Out,
  output logic [BW-1:0]              Act_Bank,
  output logic                       Sat_Flag,
  output logic                       Wr_Conflict
);
  typedef struct packed {
    logic signed [PSUM_W-1:0] psum;
    logic [ADDR_W-1:0]        addr;
    logic [VALID_W-1:0]       valid;
  } psum_stage_t;

  psum_stage_t              r_p;
  logic signed [DATA_W-1:0] r_data_i, r_data_w;
  logic                     r_en_w, r_swap, r_byp;
  logic [ROW_ID_W-1:0]      r_en_id;
  logic [BW-1:0]            r_bank_w, r_act;
  logic                     r_sat, r_conf;
  logic signed [DATA_W-1:0] r_bank [NUM_BANK];

  logic signed [PSUM_W-1:0] w_sum;
  logic                     w_sat_hit, w_mac_en, w_load;

  assign w_mac_en = !Byp_In && (|Valid_P_In);
  assign w_load   = EN_W_In && (EN_ID_In == Row_ID);

  // Reads the pre-edge active bank, so a swap only affects the following cycle.
  pe_mac_sat #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .SAT_EN(SAT_EN)) u_mac (
    .i_a       (Data_I_In),
    .i_b       (r_bank[r_act]),
    .i_c       (Psum_In),
    .o_sum     (w_sum),
    .o_sat_hit (w_sat_hit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_p      <= '0;
      r_data_i <= '0;
      r_data_w <= '0;
      r_en_w   <= 1'b0;
      r_en_id  <= '0;
      r_bank_w <= '0;
      r_swap   <= 1'b0;
      r_byp    <= 1'b0;
      r_act    <= '0;
      r_sat    <= 1'b0;
      r_conf   <= 1'b0;
      for (int i = 0; i < NUM_BANK; i++) r_bank[i] <= '0;
    end else begin
      r_data_i <= Data_I_In;
      r_data_w <= Data_W_In;
      r_en_w   <= EN_W_In;
      r_en_id  <= EN_ID_In;
      r_bank_w <= Bank_W_In;
      r_swap   <= Swap_In;
      r_byp    <= Byp_In;
      r_p.psum  <= w_mac_en ? w_sum : Psum_In;
      r_p.addr  <= Addr_P_In;
      r_p.valid <= Valid_P_In;
      if (w_mac_en && w_sat_hit) r_sat <= 1'b1;
      // The bank being read this cycle is never overwritten; the attempt is flagged instead.
      if (w_load) begin
        if (Bank_W_In == r_act) r_conf <= 1'b1;
        else                    r_bank[Bank_W_In] <= Data_W_In;
      end
      if (Swap_In) r_act <= r_act + BW'(1);
    end
  end

  assign Data_I_Out  = r_data_i;
  assign Data_W_Out  = r_data_w;
  assign EN_W_Out    = r_en_w;
  assign EN_ID_Out   = r_en_id;
  assign Bank_W_Out  = r_bank_w;
  assign Swap_Out    = r_swap;
  assign Byp_Out     = r_byp;
  assign Psum_Out    = r_p.psum;
  assign Addr_P_Out  = r_p.addr;
  assign Valid_P_Out = r_p.valid;
  assign Act_Bank    = r_act;
  assign Sat_Flag    = r_sat;
  assign Wr_Conflict = r_conf;
endmodule

// File: tb/tb_pe_dbuf.sv
// Bench for pe_dbuf: directed scenarios plus random traffic against an array/integer model;
// a saturating instance (a_*) and a wrapping instance (b_*) share the same inputs.
module tb_pe_dbuf;
  import pe_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  logic [3:0] Row_ID;
  logic signed [7:0] Data_I_In, Data_W_In;
  logic EN_W_In, Swap_In, Byp_In, Bank_W_In, Valid_P_In;
  logic [3:0] EN_ID_In;
  logic signed [23:0] Psum_In;
  logic [7:0] Addr_P_In;

  logic signed [7:0] a_di, a_dw, b_di, b_dw;
  logic a_enw, a_swap, a_byp, a_bank, a_valid, a_act, a_sat, a_conf;
  logic b_enw, b_swap, b_byp, b_bank, b_valid, b_act, b_sat, b_conf;
  logic [3:0] a_enid, b_enid;
  logic signed [23:0] a_psum, b_psum;
  logic [7:0] a_addr, b_addr;

  always #5 CLK = ~CLK;

  pe_dbuf #(.SAT_EN(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .Row_ID(Row_ID),
    .Data_I_In(Data_I_In), .Data_I_Out(a_di), .Data_W_In(Data_W_In), .Data_W_Out(a_dw),
    .EN_W_In(EN_W_In), .EN_W_Out(a_enw), .EN_ID_In(EN_ID_In), .EN_ID_Out(a_enid),
    .Bank_W_In(Bank_W_In), .Bank_W_Out(a_bank), .Swap_In(Swap_In), .Swap_Out(a_swap),
    .Byp_In(Byp_In), .Byp_Out(a_byp), .Psum_In(Psum_In), .Psum_Out(a_psum),
    .Addr_P_In(Addr_P_In), .Addr_P_Out(a_addr), .Valid_P_In(Valid_P_In), .Valid_P_Out(a_valid),
    .Act_Bank(a_act), .Sat_Flag(a_sat), .Wr_Conflict(a_conf));

  pe_dbuf #(.SAT_EN(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .Row_ID(Row_ID),
    .Data_I_In(Data_I_In), .Data_I_Out(b_di), .Data_W_In(Data_W_In), .Data_W_Out(b_dw),
    .EN_W_In(EN_W_In), .EN_W_Out(b_enw), .EN_ID_In(EN_ID_In), .EN_ID_Out(b_enid),
    .Bank_W_In(Bank_W_In), .Bank_W_Out(b_bank), .Swap_In(Swap_In), .Swap_Out(b_swap),
    .Byp_In(Byp_In), .Byp_Out(b_byp), .Psum_In(Psum_In), .Psum_Out(b_psum),
    .Addr_P_In(Addr_P_In), .Addr_P_Out(b_addr), .Valid_P_In(Valid_P_In), .Valid_P_Out(b_valid),
    .Act_Bank(b_act), .Sat_Flag(b_sat), .Wr_Conflict(b_conf));

  // Reference model state and expected outputs.
  int  m_bank [2];
  int  m_act;
  bit  m_sat, m_conf;
  logic [32:0]        e_fwd;
  logic signed [23:0] e_psum, e_wrap;
  int  n_cmp = 0, n_bad = 0;

  wire [32:0] a_fwd = {a_di, a_dw, a_enw, a_enid, a_bank, a_swap, a_byp, a_addr, a_valid};
  wire [32:0] b_fwd = {b_di, b_dw, b_enw, b_enid, b_bank, b_swap, b_byp, b_addr, b_valid};

  // Advance the model on the current inputs, then let the DUT see the same edge.
  task automatic tick();
    longint sum;
    if (RST) begin
      m_bank[0] = 0; m_bank[1] = 0; m_act = 0; m_sat = 0; m_conf = 0;
      e_fwd = '0; e_psum = '0; e_wrap = '0;
    end else begin
      e_fwd = {Data_I_In, Data_W_In, EN_W_In, EN_ID_In, Bank_W_In, Swap_In, Byp_In, Addr_P_In, Valid_P_In};
      if (Byp_In || !Valid_P_In) begin
        e_psum = Psum_In; e_wrap = Psum_In;
      end else begin
        sum = longint'(Data_I_In) * longint'(m_bank[m_act]) + longint'(Psum_In);
        e_wrap = sum[23:0];
        if (sum > 64'sd8388607)       begin e_psum = 24'sh7FFFFF; m_sat = 1; end
        else if (sum < -64'sd8388608) begin e_psum = 24'sh800000; m_sat = 1; end
        else                          e_psum = sum[23:0];
      end
      if (EN_W_In && EN_ID_In == Row_ID) begin
        if (int'(Bank_W_In) == m_act) m_conf = 1;
        else m_bank[Bank_W_In] = Data_W_In;
      end
      if (Swap_In) m_act = (m_act + 1) % 2;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Data_I_In = 0; Data_W_In = 0; EN_W_In = 0; EN_ID_In = 0; Bank_W_In = 0;
    Swap_In = 0; Byp_In = 0; Psum_In = 0; Addr_P_In = 0; Valid_P_In = 0;
  endtask

  task automatic do_reset();
    RST = 1; idle(); tick(); RST = 0;
  endtask

  task automatic load(input logic bank, input logic signed [7:0] val);
    EN_W_In = 1; EN_ID_In = Row_ID; Bank_W_In = bank; Data_W_In = val; tick();
    EN_W_In = 0;
  endtask

  task automatic swap();
    Swap_In = 1; tick(); Swap_In = 0;
  endtask

  // Leaves bank0 = w active (Act_Bank = 0) by filling it while bank1 is active.
  task automatic preload_bank0(input logic signed [7:0] w);
    do_reset(); swap(); load(1'b0, w); swap();
  endtask

  task automatic test_reset();
    RST = 1;
    Data_I_In = 8'sd77; Data_W_In = -8'sd9; EN_W_In = 1; EN_ID_In = 2; Bank_W_In = 1;
    Swap_In = 1; Byp_In = 1; Psum_In = 24'sd1234; Addr_P_In = 8'hA5; Valid_P_In = 1;
    tick();
    n_cmp++; if (a_fwd !== 33'd0) begin n_bad++; $display("FAIL reset_fwd got %h want 0", a_fwd); end
    n_cmp++; if (a_psum !== 24'sd0) begin n_bad++; $display("FAIL reset_psum got %0d want 0", a_psum); end
    n_cmp++; if ({a_act, a_sat, a_conf} !== 3'b000) begin n_bad++; $display("FAIL reset_state got %b want 000", {a_act, a_sat, a_conf}); end
    RST = 0; idle();
    Data_I_In = 8'sd5; Data_W_In = -8'sd3; Addr_P_In = 8'd7; Valid_P_In = 1; Psum_In = 24'sd11;
    tick();
    n_cmp++; if (a_fwd !== e_fwd) begin n_bad++; $display("FAIL fwd got %h want %h", a_fwd, e_fwd); end
    n_cmp++; if (a_psum !== 24'sd11) begin n_bad++; $display("FAIL fwd_psum got %0d want 11", a_psum); end
  endtask

  task automatic test_double_buffer();
    preload_bank0(8'sd3);
    EN_W_In = 1; EN_ID_In = 2; Bank_W_In = 1; Data_W_In = 8'sd4;
    Data_I_In = 8'sd10; Psum_In = 24'sd100; Valid_P_In = 1;
    tick();
    n_cmp++; if (a_psum !== 24'sd130) begin n_bad++; $display("FAIL dbuf_load_cycle got %0d want 130", a_psum); end
    EN_W_In = 0; Swap_In = 1;
    tick();
    n_cmp++; if (a_psum !== 24'sd130) begin n_bad++; $display("FAIL dbuf_swap_cycle got %0d want 130", a_psum); end
    Swap_In = 0;
    tick();
    n_cmp++; if (a_psum !== 24'sd140) begin n_bad++; $display("FAIL dbuf_after_swap got %0d want 140", a_psum); end
    n_cmp++; if (a_act !== 1'b1) begin n_bad++; $display("FAIL dbuf_act got %0d want 1", a_act); end
  endtask

  task automatic test_conflict();
    preload_bank0(8'sd3);
    EN_W_In = 1; EN_ID_In = 2; Bank_W_In = 0; Data_W_In = 8'sd7;
    Data_I_In = 8'sd1; Psum_In = 24'sd0; Valid_P_In = 1;
    tick();
    EN_W_In = 0;
    tick(); tick(); tick();
    n_cmp++; if (a_psum !== 24'sd3) begin n_bad++; $display("FAIL conflict_bank got %0d want 3", a_psum); end
    n_cmp++; if ({a_conf, b_conf} !== 2'b11) begin n_bad++; $display("FAIL conflict_flag got %b want 11", {a_conf, b_conf}); end
    // Row mismatch: bank1 must stay 0 and nothing is flagged.
    do_reset();
    EN_W_In = 1; EN_ID_In = 3; Bank_W_In = 1; Data_W_In = 8'sd9; tick();
    EN_W_In = 0; swap();
    Data_I_In = 8'sd1; Psum_In = 24'sd0; Valid_P_In = 1; tick();
    n_cmp++; if (a_psum !== 24'sd0) begin n_bad++; $display("FAIL rowmiss_bank got %0d want 0", a_psum); end
    n_cmp++; if (a_conf !== 1'b0) begin n_bad++; $display("FAIL rowmiss_flag got %b want 0", a_conf); end
  endtask

  task automatic test_saturation();
    preload_bank0(8'sd127);
    Data_I_In = 8'sd127; Psum_In = 24'sd8388600; Valid_P_In = 1;
    tick();
    n_cmp++; if (a_psum !== 24'sd8388607) begin n_bad++; $display("FAIL sat_pos got %0d want 8388607", a_psum); end
    n_cmp++; if (a_sat !== 1'b1) begin n_bad++; $display("FAIL sat_flag got %b want 1", a_sat); end
    n_cmp++; if (b_psum !== e_wrap) begin n_bad++; $display("FAIL wrap_pos got %0d want %0d", b_psum, e_wrap); end
    n_cmp++; if (b_sat !== 1'b0) begin n_bad++; $display("FAIL wrap_flag got %b want 0", b_sat); end
    Data_I_In = -8'sd128; Psum_In = -24'sd8388600;
    tick();
    n_cmp++; if (a_psum !== -24'sd8388608) begin n_bad++; $display("FAIL sat_neg got %0d want -8388608", a_psum); end
    n_cmp++; if (b_psum !== e_wrap) begin n_bad++; $display("FAIL wrap_neg got %0d want %0d", b_psum, e_wrap); end
  endtask

  task automatic test_gating();
    preload_bank0(8'sd6);
    Data_I_In = 8'sd9; Psum_In = -24'sd55; Addr_P_In = 8'h3C; Valid_P_In = 0;
    tick();
    n_cmp++; if (a_psum !== -24'sd55) begin n_bad++; $display("FAIL gate_valid got %0d want -55", a_psum); end
    n_cmp++; if (a_fwd !== e_fwd) begin n_bad++; $display("FAIL gate_valid_fwd got %h want %h", a_fwd, e_fwd); end
    Valid_P_In = 1; Byp_In = 1;
    tick();
    n_cmp++; if (a_psum !== -24'sd55) begin n_bad++; $display("FAIL gate_byp got %0d want -55", a_psum); end
    n_cmp++; if (a_fwd !== e_fwd) begin n_bad++; $display("FAIL gate_byp_fwd got %h want %h", a_fwd, e_fwd); end
    Byp_In = 0;
  endtask

  task automatic test_simultaneous();
    preload_bank0(8'sd1);
    EN_W_In = 1; EN_ID_In = 2; Bank_W_In = 1; Data_W_In = 8'sd9; Swap_In = 1;
    Data_I_In = 8'sd2; Psum_In = 24'sd0; Valid_P_In = 1;
    tick();
    n_cmp++; if (a_psum !== 24'sd2) begin n_bad++; $display("FAIL simul_cycle got %0d want 2", a_psum); end
    EN_W_In = 0; Swap_In = 0;
    tick();
    n_cmp++; if (a_psum !== 24'sd18) begin n_bad++; $display("FAIL simul_next got %0d want 18", a_psum); end
    n_cmp++; if (a_act !== 1'b1) begin n_bad++; $display("FAIL simul_act got %0d want 1", a_act); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      RST        = ($urandom_range(0, 99) == 0);
      Data_I_In  = 8'($urandom);
      Data_W_In  = 8'($urandom);
      EN_W_In    = ($urandom_range(0, 2) == 0);
      EN_ID_In   = 4'($urandom_range(0, 3));
      Bank_W_In  = 1'($urandom);
      Swap_In    = ($urandom_range(0, 5) == 0);
      Byp_In     = ($urandom_range(0, 7) == 0);
      Valid_P_In = ($urandom_range(0, 3) != 0);
      Addr_P_In  = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       Psum_In = 24'sd8388607 - 24'($urandom_range(0, 20000));
        1:       Psum_In = -24'sd8388608 + 24'($urandom_range(0, 20000));
        default: Psum_In = 24'($urandom);
      endcase
      tick();
      n_cmp++; if (a_fwd !== e_fwd || b_fwd !== e_fwd) begin n_bad++; $display("FAIL rnd_fwd c=%0d got %h/%h want %h", c, a_fwd, b_fwd, e_fwd); end
      n_cmp++; if (a_psum !== e_psum) begin n_bad++; $display("FAIL rnd_psum_sat c=%0d got %0d want %0d", c, a_psum, e_psum); end
      n_cmp++; if (b_psum !== e_wrap) begin n_bad++; $display("FAIL rnd_psum_wrap c=%0d got %0d want %0d", c, b_psum, e_wrap); end
      n_cmp++; if (a_act !== 1'(m_act) || b_act !== 1'(m_act)) begin n_bad++; $display("FAIL rnd_act c=%0d got %0d/%0d want %0d", c, a_act, b_act, m_act); end
      n_cmp++; if (a_sat !== m_sat || b_sat !== 1'b0) begin n_bad++; $display("FAIL rnd_sat c=%0d got %b/%b want %b/0", c, a_sat, b_sat, m_sat); end
      n_cmp++; if (a_conf !== m_conf || b_conf !== m_conf) begin n_bad++; $display("FAIL rnd_conf c=%0d got %b/%b want %b", c, a_conf, b_conf, m_conf); end
    end
    RST = 0;
  endtask

  initial begin
    Row_ID = 4'd2;
    RST = 1'b0;
    idle();
    test_reset();
    test_double_buffer();
    test_conflict();
    test_saturation();
    test_gating();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
